// File: rtl/mult8_error_monitor.sv
// Error-statistics collector for an 8x8 approximate multiplier.
// Accumulates the error count, the saturating sum of error distances and the maximum error distance over one run of N_SAMPLES beats.
module mult8_error_monitor #(
    parameter int N_SAMPLES = 65536,
    parameter int CNT_W     = 17,
    parameter int SUM_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [15:0]      in_p,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [SUM_W-1:0] ed_sum,
    output logic [15:0]      ed_max
);

    // state | meaning
    // IDLE  | waiting for start, not accepting beats
    // RUN   | accepting beats until N_SAMPLES have been taken
    // DRAIN | last beat taken, waiting for S1/S2 to empty
    // DONE  | stats final and held, start begins a new run
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int                WIDE_W     = ((SUM_W > 16) ? SUM_W : 16) + 1;
    localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'(N_SAMPLES - 1);
    localparam logic [WIDE_W-1:0] SUM_MAX    = (WIDE_W'(1) << SUM_W) - WIDE_W'(1);

    state_t            state;
    logic              s1_valid;
    logic [7:0]        s1_a;
    logic [7:0]        s1_b;
    logic [15:0]       s1_p;
    logic              s2_valid;
    logic [15:0]       s2_ed;

    logic              accept;
    logic [15:0]       exact;
    logic [15:0]       ed_next;
    logic [WIDE_W-1:0] sum_wide;
    logic [SUM_W-1:0]  sum_next;

    assign accept   = in_valid & in_ready;
    assign exact    = {8'd0, s1_a} * {8'd0, s1_b};
    assign ed_next  = (exact >= s1_p) ? (exact - s1_p) : (s1_p - exact);
    assign sum_wide = WIDE_W'(ed_sum) + WIDE_W'(s2_ed);
    assign sum_next = (sum_wide > SUM_MAX) ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            s1_valid     <= 1'b0;
            s1_a         <= 8'd0;
            s1_b         <= 8'd0;
            s1_p         <= 16'd0;
            s2_valid     <= 1'b0;
            s2_ed        <= 16'd0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_count <= '0;
            err_count    <= '0;
            ed_sum       <= '0;
            ed_max       <= 16'd0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a <= in_a;
                s1_b <= in_b;
                s1_p <= in_p;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_ed <= ed_next;
            end

            if (s2_valid) begin
                if (s2_ed != 16'd0) begin
                    err_count <= err_count + CNT_W'(1);
                end
                ed_sum <= sum_next;
                if (s2_ed > ed_max) begin
                    ed_max <= s2_ed;
                end
            end

            case (state)
                IDLE, DONE: begin
                    // The pipeline is empty here, so clearing cannot collide with accumulation.
                    if (start) begin
                        state        <= RUN;
                        in_ready     <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        sample_count <= '0;
                        err_count    <= '0;
                        ed_sum       <= '0;
                        ed_max       <= 16'd0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        sample_count <= sample_count + CNT_W'(1);
                        if (sample_count == LAST_COUNT) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // With S1 empty, the beat in S2 is accumulated on this same edge.
                    if (!s1_valid) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult8_error_monitor.sv
// Bench for mult8_error_monitor: a transaction-level model checks one instance every cycle,
// and a second small-accumulator instance covers saturation and backpressure timing.
module tb_mult8_error_monitor;

    localparam int N1 = 4;
    localparam int N2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instance 1: N_SAMPLES=4, default widths
    logic        rst1 = 1'b0, start1 = 1'b0, in_valid1 = 1'b0;
    logic [7:0]  in_a1 = '0, in_b1 = '0;
    logic [15:0] in_p1 = '0;
    logic        in_ready1, busy1, done1;
    logic [16:0] sample_count1, err_count1;
    logic [31:0] ed_sum1;
    logic [15:0] ed_max1;

    mult8_error_monitor #(.N_SAMPLES(N1), .CNT_W(17), .SUM_W(32)) dut1 (
        .clk(clk), .rst_n(rst1), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_p(in_p1), .busy(busy1), .done(done1),
        .sample_count(sample_count1), .err_count(err_count1), .ed_sum(ed_sum1), .ed_max(ed_max1));

    // Instance 2: N_SAMPLES=3, 8-bit saturating sum
    logic        rst2 = 1'b0, start2 = 1'b0, in_valid2 = 1'b0;
    logic [7:0]  in_a2 = '0, in_b2 = '0;
    logic [15:0] in_p2 = '0;
    logic        in_ready2, busy2, done2;
    logic [16:0] sample_count2, err_count2;
    logic [7:0]  ed_sum2;
    logic [15:0] ed_max2;

    mult8_error_monitor #(.N_SAMPLES(N2), .CNT_W(17), .SUM_W(8)) dut2 (
        .clk(clk), .rst_n(rst2), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a2), .in_b(in_b2), .in_p(in_p2), .busy(busy2), .done(done2),
        .sample_count(sample_count2), .err_count(err_count2), .ed_sum(ed_sum2), .ed_max(ed_max2));

    // Behavioural model of instance 1: accepted beats wait in a queue until their due edge.
    typedef struct {
        longint ed;
        longint due;
    } pend_t;

    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;
    pend_t  q[$];
    int     m_phase = P_IDLE;
    longint m_cnt = 0, m_errs = 0, m_sum = 0, m_max = 0;
    longint cyc = 0, last_due = 0;
    bit     chk_en = 1'b0;

    always @(posedge clk) begin
        pend_t  e;
        longint d;
        bit     acc;
        cyc++;
        if (!rst1) begin
            m_phase = P_IDLE;
            m_cnt = 0; m_errs = 0; m_sum = 0; m_max = 0;
            q.delete();
        end else begin
            while (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                if (e.ed != 0) m_errs++;
                m_sum = m_sum + e.ed;
                if (m_sum > 64'hFFFF_FFFF) m_sum = 64'hFFFF_FFFF;
                if (e.ed > m_max) m_max = e.ed;
            end
            acc = in_valid1 && (m_phase == P_RUN);
            if (acc) begin
                d = longint'(in_a1) * longint'(in_b1) - longint'(in_p1);
                if (d < 0) d = -d;
                q.push_back('{ed: d, due: cyc + 2});
                m_cnt++;
            end
            if (m_phase == P_RUN && acc && m_cnt == N1) begin
                m_phase = P_DRAIN;
                last_due = cyc + 2;
            end else if (m_phase == P_DRAIN && cyc == last_due) begin
                m_phase = P_DONE;
            end else if ((m_phase == P_IDLE || m_phase == P_DONE) && start1) begin
                m_phase = P_RUN;
                m_cnt = 0; m_errs = 0; m_sum = 0; m_max = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", longint'(in_ready1), longint'(m_phase == P_RUN));
            chk("busy", longint'(busy1), longint'(m_phase == P_RUN || m_phase == P_DRAIN));
            chk("done", longint'(done1), longint'(m_phase == P_DONE));
            chk("sample_count", longint'(sample_count1), m_cnt);
            chk("err_count", longint'(err_count1), m_errs);
            chk("ed_sum", longint'(ed_sum1), m_sum);
            chk("ed_max", longint'(ed_max1), m_max);
        end
    end

    // Drive tasks set inputs right after a falling edge and return at the next falling edge.
    task automatic beat1(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p, input logic v);
        in_valid1 = v; in_a1 = a; in_b1 = b; in_p1 = p;
        @(negedge clk);
    endtask

    task automatic beat2(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p, input logic v);
        in_valid2 = v; in_a2 = a; in_b2 = b; in_p2 = p;
        @(negedge clk);
    endtask

    task automatic wait_done1(input int limit);
        int k = 0;
        while (!done1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk("done1_within_bound", longint'(done1), 1);
    endtask

    task automatic mixed_run1(input bit poke_start);
        start1 = 1'b1; @(negedge clk); start1 = 1'b0;
        beat1(8'd3, 8'd5, 16'd14, 1'b1);
        start1 = poke_start;
        beat1(8'd3, 8'd5, 16'd16, 1'b1);
        start1 = 1'b0;
        beat1(8'd255, 8'd255, 16'd65025, 1'b1);
        beat1(8'd0, 8'd7, 16'd2, 1'b1);
        in_valid1 = 1'b0;
        wait_done1(10);
        chk("mixed_sample_count", longint'(sample_count1), 4);
        chk("mixed_err_count", longint'(err_count1), 3);
        chk("mixed_ed_sum", longint'(ed_sum1), 4);
        chk("mixed_ed_max", longint'(ed_max1), 2);
    endtask

    task automatic check_stats2(input string tag, input longint s, input longint e,
                                input longint sum, input longint mx);
        chk({tag, "_sample_count"}, longint'(sample_count2), s);
        chk({tag, "_err_count"}, longint'(err_count2), e);
        chk({tag, "_ed_sum"}, longint'(ed_sum2), sum);
        chk({tag, "_ed_max"}, longint'(ed_max2), mx);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        @(negedge clk); @(negedge clk);
        chk_en = 1'b1;
        chk("reset_in_ready2", longint'(in_ready2), 0);
        chk("reset_done2", longint'(done2), 0);
        rst1 = 1'b1; rst2 = 1'b1;
        @(negedge clk);

        // Mixed-sign errors, then start in DONE clears the stats
        mixed_run1(1'b0);
        start1 = 1'b1; @(negedge clk); start1 = 1'b0;
        chk("restart_busy", longint'(busy1), 1);
        chk("restart_done", longint'(done1), 0);
        chk("restart_in_ready", longint'(in_ready1), 1);
        chk("restart_ed_sum", longint'(ed_sum1), 0);
        chk("restart_err_count", longint'(err_count1), 0);

        // Reset after two accepts, then a clean run with a start poked mid-RUN
        beat1(8'd200, 8'd200, 16'd1, 1'b1);
        beat1(8'd17, 8'd3, 16'd0, 1'b1);
        rst1 = 1'b0; in_valid1 = 1'b0;
        @(negedge clk);
        chk("midreset_in_ready", longint'(in_ready1), 0);
        chk("midreset_busy", longint'(busy1), 0);
        chk("midreset_sample_count", longint'(sample_count1), 0);
        chk("midreset_ed_max", longint'(ed_max1), 0);
        rst1 = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("midreset_ed_sum_after", longint'(ed_sum1), 0);
        mixed_run1(1'b1);

        // Backpressure on instance 2: valid pattern 1,0,0,1,0,1
        start2 = 1'b1; @(negedge clk); start2 = 1'b0;
        beat2(8'd2, 8'd3, 16'd5, 1'b1);
        beat2(8'd99, 8'd99, 16'd0, 1'b0);
        beat2(8'd99, 8'd99, 16'd0, 1'b0);
        beat2(8'd4, 8'd4, 16'd20, 1'b1);
        beat2(8'd99, 8'd99, 16'd0, 1'b0);
        beat2(8'd1, 8'd1, 16'd0, 1'b1);
        in_valid2 = 1'b0;
        chk("bp_in_ready_after_last", longint'(in_ready2), 0);
        chk("bp_busy_after_last", longint'(busy2), 1);
        chk("bp_done_e0", longint'(done2), 0);
        chk("bp_count_e0", longint'(sample_count2), 3);
        @(negedge clk);
        chk("bp_done_e1", longint'(done2), 0);
        @(negedge clk);
        chk("bp_done_e2", longint'(done2), 1);
        chk("bp_busy_e2", longint'(busy2), 0);
        check_stats2("bp", 3, 3, 6, 4);

        // Same beats without gaps
        start2 = 1'b1; @(negedge clk); start2 = 1'b0;
        beat2(8'd2, 8'd3, 16'd5, 1'b1);
        beat2(8'd4, 8'd4, 16'd20, 1'b1);
        beat2(8'd1, 8'd1, 16'd0, 1'b1);
        in_valid2 = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("nogap_done", longint'(done2), 1);
        check_stats2("nogap", 3, 3, 6, 4);

        // Saturation: ed = 200, 100, 50 into an 8-bit sum
        start2 = 1'b1; @(negedge clk); start2 = 1'b0;
        beat2(8'd1, 8'd250, 16'd50, 1'b1);
        beat2(8'd0, 8'd0, 16'd100, 1'b1);
        beat2(8'd10, 8'd10, 16'd50, 1'b1);
        in_valid2 = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("sat_done", longint'(done2), 1);
        check_stats2("sat", 3, 3, 255, 200);

        // Randomized traffic on instance 1 with stray starts and rare resets
        for (int i = 0; i < 3000; i++) begin
            logic [7:0]  a, b;
            logic [15:0] p;
            int          sel;
            a = 8'($urandom);
            b = 8'($urandom);
            sel = $urandom_range(0, 2);
            if (sel == 0)      p = {8'd0, a} * {8'd0, b};
            else if (sel == 1) p = ({8'd0, a} * {8'd0, b}) + 16'($urandom_range(0, 6)) - 16'd3;
            else               p = 16'($urandom);
            start1 = ($urandom_range(0, 7) == 0);
            rst1   = ($urandom_range(0, 299) != 0);
            beat1(a, b, p, ($urandom_range(0, 3) != 0));
        end
        start1 = 1'b0; rst1 = 1'b1; in_valid1 = 1'b0;
        @(negedge clk); @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
